// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-to-binary tracker.
//   track_state_t : tracker FSM states
//   DEFAULT_WIDTH : default Gray/binary code width
//   DEFAULT_ERR_W : default step-error counter width
package gray_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    TRACKING = 2'd1,
    RESYNC   = 2'd2
  } track_state_t;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_ERR_W = 8;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter.
//   gray : Gray-coded input, WIDTH bits
//   bin  : binary equivalent, WIDTH bits
// Each binary bit is the XOR of its Gray bit and every Gray bit above it,
// which is the unrolled form of b[i] = b[i+1] ^ g[i].
module gray2bin
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_to_binary_tracker.sv
// Gray-code position tracker: decodes Gray samples to binary and classifies
// each step against the previous sample as +1, -1, hold or error.
//   clk, reset          : clock, synchronous active-high reset
//   gray_valid, gray_in : input sample strobe and Gray-coded value
//   err_clr             : synchronous clear of err_count (wins over increment)
//   bin_valid, bin_out  : decoded sample, two cycles after acceptance
//   dir_up, dir_dn      : +1 / -1 step (mod 2^WIDTH), qualified by bin_valid
//   step_err            : non-adjacent step, qualified by bin_valid
//   locked              : FSM is in TRACKING
//   err_count           : saturating step-error count
//
// state    | meaning
// ---------+-------------------------------------------------------------
// UNLOCKED | no reference yet; next sample becomes the reference
// TRACKING | samples are checked against the reference
// RESYNC   | last step was an error; next sample is taken unchecked
module gray_to_binary_tracker
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ERR_W = DEFAULT_ERR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gray_valid,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic             bin_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic             dir_up,
  output logic             dir_dn,
  output logic             step_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [WIDTH-1:0] STEP_UP = WIDTH'(1);
  localparam logic [WIDTH-1:0] STEP_DN = '1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // Stage 1: registered sample and its binary value
  logic [WIDTH-1:0] conv_bin;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_bin;

  gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .gray (gray_in),
    .bin  (conv_bin)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_bin   <= '0;
    end else begin
      s1_valid <= gray_valid;
      if (gray_valid) s1_bin <= conv_bin;
    end
  end

  // Step classification; modular subtraction makes wrap-around adjacent
  track_state_t     state_q, state_d;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] delta;
  logic             step_bad;

  assign delta    = s1_bin - ref_q;
  assign step_bad = (delta != STEP_UP) && (delta != STEP_DN) && (delta != '0);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= UNLOCKED;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (s1_valid) begin
      case (state_q)
        UNLOCKED: state_d = TRACKING;
        TRACKING: state_d = step_bad ? RESYNC : TRACKING;
        RESYNC:   state_d = TRACKING;
        default:  state_d = UNLOCKED;
      endcase
    end
  end

  // FSM outputs: flags only when a checked sample is in stage 1
  logic up_d, dn_d, err_d;

  always_comb begin
    up_d  = 1'b0;
    dn_d  = 1'b0;
    err_d = 1'b0;
    if (s1_valid && (state_q == TRACKING)) begin
      up_d  = (delta == STEP_UP);
      dn_d  = (delta == STEP_DN);
      err_d = step_bad;
    end
  end

  // Stage 2: outputs, reference and error counter
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_valid <= 1'b0;
      bin_out   <= '0;
      dir_up    <= 1'b0;
      dir_dn    <= 1'b0;
      step_err  <= 1'b0;
      ref_q     <= '0;
      err_count <= '0;
    end else begin
      bin_valid <= s1_valid;
      bin_out   <= s1_valid ? s1_bin : '0;
      dir_up    <= up_d;
      dir_dn    <= dn_d;
      step_err  <= err_d;
      if (s1_valid) ref_q <= s1_bin;
      if (err_clr)
        err_count <= '0;
      else if (err_d && (err_count != ERR_MAX))
        err_count <= err_count + ERR_W'(1);
    end
  end

  // Follows the state register, so it moves together with bin_valid
  assign locked = (state_q == TRACKING);

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
module tb_gray_to_binary_tracker;

  localparam int W  = 4;
  localparam int EW = 8;
  localparam int NV = 21;

  logic          clk = 1'b0;
  logic          reset;
  logic          gray_valid;
  logic [W-1:0]  gray_in;
  logic          err_clr;
  logic          bin_valid;
  logic [W-1:0]  bin_out;
  logic          dir_up, dir_dn, step_err, locked;
  logic [EW-1:0] err_count;

  gray_to_binary_tracker #(.WIDTH(W), .ERR_W(EW)) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_valid (gray_valid),
    .gray_in    (gray_in),
    .err_clr    (err_clr),
    .bin_valid  (bin_valid),
    .bin_out    (bin_out),
    .dir_up     (dir_up),
    .dir_dn     (dir_dn),
    .step_err   (step_err),
    .locked     (locked),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [3:0] gray;
    logic [3:0] bin;
    logic       up, dn, err, lock;
    int         cnt;
  } vec_t;

  typedef struct {
    logic [3:0] bin;
    logic       up, dn, err, lock;
    int         cnt;
    int         cyc;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb [$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 0;

  int         m_state;
  logic [3:0] m_ref;
  int         m_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bin_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(bin_valid), 0);
        end else begin
          mon_e = sb.pop_front();
          check("latency",  cyc, mon_e.cyc);
          check("bin_out",  32'(bin_out),  32'(mon_e.bin));
          check("dir_up",   32'(dir_up),   32'(mon_e.up));
          check("dir_dn",   32'(dir_dn),   32'(mon_e.dn));
          check("step_err", 32'(step_err), 32'(mon_e.err));
          check("locked",   32'(locked),   32'(mon_e.lock));
          check("err_count", 32'(err_count), mon_e.cnt);
        end
      end else begin
        check("idle_zero", {28'd0, dir_up, dir_dn, step_err, |bin_out}, 0);
      end
    end
  end

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    return b;
  endfunction

  task automatic drive(input logic v, input logic [3:0] g, input logic clr, input logic rst);
    @(posedge clk);
    #1;
    gray_valid = v;
    gray_in    = g;
    err_clr    = clr;
    reset      = rst;
  endtask

  task automatic model_reset();
    m_state = 0;
    m_ref   = 4'd0;
    m_cnt   = 0;
  endtask

  // clr: err_clr will be high while this sample is being classified
  task automatic model_push(input logic [3:0] g, input logic clr);
    logic [3:0] b, d;
    logic up, dn, err;
    b = g2b(g);
    up = 0; dn = 0; err = 0;
    if (m_state == 1) begin
      d   = b - m_ref;
      up  = (d == 4'd1);
      dn  = (d == 4'd15);
      err = (d != 4'd0) && !up && !dn;
      m_state = err ? 2 : 1;
    end else begin
      m_state = 1;
    end
    m_ref = b;
    if (clr) m_cnt = 0;
    else if (err && m_cnt < 255) m_cnt++;
    sb.push_back('{b, up, dn, err, (m_state == 1), m_cnt, cyc + 2});
  endtask

  task automatic drain();
    int n;
    n = 0;
    drive(0, 4'd0, 0, 0);
    while (sb.size() != 0 && n < 10) begin
      drive(0, 4'd0, 0, 0);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    drive(0, 4'd0, 0, 1);
    drive(0, 4'd0, 0, 0);
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g;
    reset = 1; gray_valid = 0; gray_in = '0; err_clr = 0;
    model_reset();

    // rst, gray, bin, up, dn, err, lock, cnt
    vecs[0]  = '{1, 4'b0000, 4'd0,  0, 0, 0, 1, 0};
    vecs[1]  = '{0, 4'b0001, 4'd1,  1, 0, 0, 1, 0};
    vecs[2]  = '{0, 4'b0011, 4'd2,  1, 0, 0, 1, 0};
    vecs[3]  = '{0, 4'b0010, 4'd3,  1, 0, 0, 1, 0};
    vecs[4]  = '{1, 4'b1000, 4'd15, 0, 0, 0, 1, 0};
    vecs[5]  = '{0, 4'b0000, 4'd0,  1, 0, 0, 1, 0};
    vecs[6]  = '{0, 4'b1000, 4'd15, 0, 1, 0, 1, 0};
    vecs[7]  = '{1, 4'b0000, 4'd0,  0, 0, 0, 1, 0};
    vecs[8]  = '{0, 4'b0011, 4'd2,  0, 0, 1, 0, 1};
    vecs[9]  = '{0, 4'b0010, 4'd3,  0, 0, 0, 1, 1};
    vecs[10] = '{0, 4'b0110, 4'd4,  1, 0, 0, 1, 1};
    vecs[11] = '{1, 4'b0011, 4'd2,  0, 0, 0, 1, 0};
    vecs[12] = '{0, 4'b0011, 4'd2,  0, 0, 0, 1, 0};
    vecs[13] = '{1, 4'b1111, 4'd10, 0, 0, 0, 1, 0};
    vecs[14] = '{0, 4'b1101, 4'd9,  0, 1, 0, 1, 0};
    vecs[15] = '{1, 4'b0000, 4'd0,  0, 0, 0, 1, 0};
    vecs[16] = '{0, 4'b0100, 4'd7,  0, 0, 1, 0, 1};
    vecs[17] = '{0, 4'b1100, 4'd8,  0, 0, 0, 1, 1};
    vecs[18] = '{0, 4'b0101, 4'd6,  0, 0, 1, 0, 2};
    vecs[19] = '{1, 4'b0110, 4'd4,  0, 0, 0, 1, 0};
    vecs[20] = '{0, 4'b0010, 4'd3,  0, 1, 0, 1, 0};

    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    mon_en = 1;
    @(negedge clk);
    check("rst_locked", 32'(locked), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_bin_valid", 32'(bin_valid), 0);

    // Table-driven vectors, back-to-back within each group
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) begin
        drain();
        do_reset();
      end
      drive(1, vecs[i].gray, 0, 0);
      sb.push_back('{vecs[i].bin, vecs[i].up, vecs[i].dn, vecs[i].err,
                     vecs[i].lock, vecs[i].cnt, cyc + 2});
    end
    drain();

    // Saturation: alternating 0 / 8 gives an error on every other sample
    do_reset();
    for (int i = 0; i < 600; i++) begin
      g = i[0] ? 4'b1100 : 4'b0000;
      drive(1, g, 0, 0);
      model_push(g, 0);
    end
    drain();
    @(negedge clk);
    check("sat_hold", 32'(err_count), 255);

    // err_clr coincident with an error increment
    drive(1, 4'b0000, 0, 0);
    model_push(4'b0000, 0);
    drive(1, 4'b1100, 0, 0);
    model_push(4'b1100, 1);
    drive(0, 4'd0, 1, 0);
    drain();
    @(negedge clk);
    check("clr_wins", 32'(err_count), 0);

    // Reset with two samples in flight
    do_reset();
    drive(1, 4'b0000, 0, 0); model_push(4'b0000, 0);
    drive(1, 4'b0100, 0, 0); model_push(4'b0100, 0);
    drive(1, 4'b0101, 0, 0); model_push(4'b0101, 0);
    drain();
    @(negedge clk);
    check("pre_rst_locked", 32'(locked), 1);
    check("pre_rst_err_count", 32'(err_count), 1);
    drive(1, 4'b0001, 0, 0);
    drive(1, 4'b0011, 1, 1);
    drive(0, 4'd0, 0, 0);
    model_reset();
    @(negedge clk);
    check("midrst_locked", 32'(locked), 0);
    check("midrst_err_count", 32'(err_count), 0);
    repeat (3) drive(0, 4'd0, 0, 0);
    drive(1, 4'b0111, 0, 0);
    model_push(4'b0111, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
